// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and single-cycle access sequencer for the
// single-ported data memory; port 0 = memory stage, port 1 = loader/debug DMA.
//
// state  | meaning
// IDLE   | waiting for a request; grant is chosen and memory lines registered
// ACCESS | memory enables high for exactly one cycle; read data captured
// DONE   | ack of the granted port high; returns to IDLE unconditionally
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   gnt_id;
    logic   sel;

    // On a tie the port that did not win last time is served.
    always_comb begin
        sel = p1_req;
        if (p0_req && p1_req) begin
            sel = ~last_grant;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt_id     <= 1'b0;
            mem_adr    <= '0;
            mem_wdata  <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        state      <= ACCESS;
                        last_grant <= sel;
                        gnt_id     <= sel;
                        if (sel) begin
                            mem_adr   <= p1_addr;
                            mem_wdata <= p1_wdata;
                            mem_wr_en <= p1_we;
                            mem_rd_en <= ~p1_we;
                        end else begin
                            mem_adr   <= p0_addr;
                            mem_wdata <= p0_wdata;
                            mem_wr_en <= p0_we;
                            mem_rd_en <= ~p0_we;
                        end
                    end
                end
                ACCESS: begin
                    state     <= DONE;
                    mem_rd_en <= 1'b0;
                    mem_wr_en <= 1'b0;
                    if (mem_rd_en) begin
                        if (gnt_id) begin
                            p1_rdata <= mem_rdata;
                        end else begin
                            p0_rdata <= mem_rdata;
                        end
                    end
                    if (gnt_id) begin
                        p1_ack <= 1'b1;
                    end else begin
                        p0_ack <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset/pulse corner sequences,
// and random traffic checked against a transaction-level round-robin model.
module tb_dmem_arbiter;

    logic       clk;
    logic       rst;
    logic       p0_req, p0_we, p0_ack;
    logic [7:0] p0_addr, p0_wdata, p0_rdata;
    logic       p1_req, p1_we, p1_ack;
    logic [7:0] p1_addr, p1_wdata, p1_rdata;
    logic       busy;
    logic [7:0] mem_adr, mem_wdata, mem_rdata;
    logic       mem_rd_en, mem_wr_en;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .busy(busy),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory attached to the arbiter; not reset by rst.
    logic [7:0] ram [256];
    logic       preload = 1'b1;
    assign mem_rdata = ram[mem_adr];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            ram[8'h01] <= 8'h11;
            ram[8'h02] <= 8'h22;
            ram[8'h20] <= 8'h3C;
        end else if (mem_wr_en) begin
            ram[mem_adr] <= mem_wdata;
        end
    end

    logic [7:0] ref_mem [256];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, exp);
        end
    endtask

    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_en <= 1'b0;
        end else begin
            chk1("en_exclusive", mem_rd_en & mem_wr_en, 1'b0);
            chk1("en_back_to_back", prev_en & (mem_rd_en | mem_wr_en), 1'b0);
            chk1("ack_exclusive", p0_ack & p1_ack, 1'b0);
            prev_en <= mem_rd_en | mem_wr_en;
        end
    end

    task automatic check_reset_values();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rd_en", mem_rd_en, 1'b0);
        chk1("rst_wr_en", mem_wr_en, 1'b0);
        chk8("rst_adr", mem_adr, 8'h00);
        chk8("rst_wdata", mem_wdata, 8'h00);
        chk1("rst_ack0", p0_ack, 1'b0);
        chk1("rst_ack1", p1_ack, 1'b0);
        chk8("rst_rdata0", p0_rdata, 8'h00);
        chk8("rst_rdata1", p1_rdata, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Entered just after a rising edge with the arbiter in IDLE; spans the
    // three cycles of one transaction and leaves just after the return to IDLE.
    task automatic run_round(input string tag,
                             input logic r0, input logic we0, input logic [7:0] a0, input logic [7:0] d0,
                             input logic r1, input logic we1, input logic [7:0] a1, input logic [7:0] d1,
                             input logic eg, input logic [7:0] er0, input logic [7:0] er1);
        logic       gwe;
        logic [7:0] ga, gd;
        gwe = eg ? we1 : we0;
        ga  = eg ? a1 : a0;
        gd  = eg ? d1 : d0;
        p0_req = r0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
        @(negedge clk);
        chk1({tag, "_idle_busy"}, busy, 1'b0);
        chk1({tag, "_idle_en"}, mem_rd_en | mem_wr_en, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk1({tag, "_wr_en"}, mem_wr_en, gwe);
        chk1({tag, "_rd_en"}, mem_rd_en, ~gwe);
        chk8({tag, "_adr"}, mem_adr, ga);
        chk8({tag, "_wdata"}, mem_wdata, gd);
        chk1({tag, "_acc_busy"}, busy, 1'b1);
        chk1({tag, "_acc_ack"}, p0_ack | p1_ack, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk1({tag, "_ack0"}, p0_ack, eg == 1'b0);
        chk1({tag, "_ack1"}, p1_ack, eg == 1'b1);
        chk1({tag, "_done_en"}, mem_rd_en | mem_wr_en, 1'b0);
        chk1({tag, "_done_busy"}, busy, 1'b1);
        chk8({tag, "_rdata0"}, p0_rdata, er0);
        chk8({tag, "_rdata1"}, p1_rdata, er1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       r0, we0;
        logic [7:0] a0, d0;
        logic       r1, we1;
        logic [7:0] a1, d1;
        logic       eg;
        logic [7:0] er0, er1;
    } vec_t;

    vec_t vecs [12];

    logic       pend [2];
    logic       m_we [2];
    logic [7:0] m_a  [2];
    logic [7:0] m_d  [2];
    logic [7:0] m_rd [2];
    logic       lg;

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hA5, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'hA5, 8'h3C};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'hFF, 1'b1, 8'hA5, 8'h3C};
        vecs[4]  = '{1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 8'h11, 8'h3C};
        vecs[5]  = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 8'h11, 8'h22};
        vecs[6]  = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'hFF, 8'h22};
        vecs[7]  = '{1'b1, 1'b1, 8'h02, 8'h5A, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 8'hFF, 8'h11};
        vecs[8]  = '{1'b1, 1'b1, 8'h02, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h11};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 8'hFF, 8'h5A};
        vecs[10] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 8'h10, 8'h66, 1'b0, 8'hA5, 8'h5A};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'h66, 1'b1, 8'hA5, 8'h5A};

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_mem[8'h01] = 8'h11;
        ref_mem[8'h02] = 8'h22;
        ref_mem[8'h20] = 8'h3C;

        p0_we = 1'b0; p0_addr = 8'h00; p0_wdata = 8'h00;
        p1_we = 1'b0; p1_addr = 8'h00; p1_wdata = 8'h00;
        do_reset();
        preload = 1'b0;

        // Directed vectors: single-port traffic, contention, isolation, tie-break.
        for (int i = 0; i < 12; i++) begin
            run_round($sformatf("vec%0d", i),
                      vecs[i].r0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
                      vecs[i].r1, vecs[i].we1, vecs[i].a1, vecs[i].d1,
                      vecs[i].eg, vecs[i].er0, vecs[i].er1);
            if (vecs[i].eg == 1'b0 && vecs[i].we0) ref_mem[vecs[i].a0] = vecs[i].d0;
            if (vecs[i].eg == 1'b1 && vecs[i].we1) ref_mem[vecs[i].a1] = vecs[i].d1;
        end

        // Reset in the ACCESS cycle of a port 0 write: memory still commits.
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h30; p0_wdata = 8'h77;
        p1_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        p0_req = 1'b0;
        @(negedge clk);
        chk1("rstacc_wr_en_before", mem_wr_en, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1 rst = 1'b0;
        ref_mem[8'h30] = 8'h77;
        run_round("rstacc_readback", 1'b0, 1'b0, 8'h00, 8'h00,
                  1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 8'h00, 8'h77);

        // One-cycle request pulse on port 0; port 1 requests during ACCESS.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
        p1_req = 1'b0;
        @(posedge clk);
        #1 p0_req = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h20;
        @(negedge clk);
        chk1("pulse_rd_en", mem_rd_en, 1'b1);
        chk8("pulse_adr", mem_adr, 8'h10);
        @(posedge clk);
        @(negedge clk);
        chk1("pulse_ack0", p0_ack, 1'b1);
        chk1("pulse_ack1_early", p1_ack, 1'b0);
        chk8("pulse_rdata0", p0_rdata, ref_mem[8'h10]);
        @(posedge clk);
        @(negedge clk);
        chk1("late_idle_busy", busy, 1'b0);
        chk1("late_idle_en", mem_rd_en | mem_wr_en, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk1("late_rd_en", mem_rd_en, 1'b1);
        chk8("late_adr", mem_adr, 8'h20);
        @(posedge clk);
        @(negedge clk);
        chk1("late_ack1", p1_ack, 1'b1);
        chk1("late_ack0", p0_ack, 1'b0);
        chk8("late_rdata1", p1_rdata, ref_mem[8'h20]);
        @(posedge clk);
        #1 p1_req = 1'b0;

        // Random traffic against a transaction-level round-robin model.
        do_reset();
        lg = 1'b1;
        m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic       g, r0, r1;
            logic [7:0] addr;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && (n == 0 || $urandom_range(99) < 70)) begin
                    pend[p] = 1'b1;
                    m_we[p] = 1'($urandom_range(1));
                    addr    = ($urandom_range(1) == 1) ? 8'($urandom_range(7)) : 8'($urandom_range(255));
                    m_a[p]  = addr;
                    m_d[p]  = 8'($urandom_range(255));
                end
            end
            r0 = pend[0];
            r1 = pend[1];
            if (!r0 && !r1) begin
                p0_req = 1'b0;
                p1_req = 1'b0;
                @(negedge clk);
                chk1("rand_idle_busy", busy, 1'b0);
                chk1("rand_idle_en", mem_rd_en | mem_wr_en, 1'b0);
                @(posedge clk);
                #1;
            end else begin
                g = (r0 && r1) ? ~lg : r1;
                if (m_we[g]) ref_mem[m_a[g]] = m_d[g];
                else         m_rd[g] = ref_mem[m_a[g]];
                lg = g;
                pend[g] = 1'b0;
                run_round($sformatf("rand%0d", n),
                          r0, m_we[0], m_a[0], m_d[0],
                          r1, m_we[1], m_a[1], m_d[1],
                          g, m_rd[0], m_rd[1]);
            end
        end

        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-ported 8-bit data memory used by the memory stage. Port 0 serves the pipeline memory stage and port 1 serves a secondary master (loader/debug DMA). Each granted transaction is driven onto the memory's address/data/read-enable/write-enable lines for exactly one cycle. Read data is captured per port, and completion is signalled with a one-cycle acknowledge. Fairness between the two ports is round-robin.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- p0_req  in  1  port 0 request; held high until p0_ack
- p0_we  in  1  port 0 operation: 1 = write, 0 = read
- p0_addr  in  ADDR_W  port 0 address
- p0_wdata  in  DATA_W  port 0 write data
- p0_ack  out  1  one-cycle completion pulse for port 0
- p0_rdata  out  DATA_W  port 0 read data, held until next port 0 read completes
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1
- busy  out  1  high whenever FSM is not IDLE
- mem_adr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory write data
- mem_rd_en  out  1  to memory read enable
- mem_wr_en  out  1  to memory write enable
- mem_rdata  in  DATA_W  from memory; combinational read of mem_adr

## Operation
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - Neither request high: stay in IDLE.
  - Otherwise select a port and go to ACCESS.
- Selection:
  - Only one port requesting: grant that port.
  - Both requesting: grant the port != last_grant.
  - last_grant is updated to the granted port on the IDLE->ACCESS transition.
- On grant (IDLE->ACCESS edge):
  - Register mem_adr and mem_wdata from the granted port.
  - If we=1: mem_wr_en<=1, mem_rd_en<=0.
  - If we=0: mem_rd_en<=1, mem_wr_en<=0.
  - Latch granted-port id in gnt_id.
- ACCESS (one cycle):
  - Memory enables are high.
  - On the ACCESS->DONE edge, a write commits in memory.
  - For a read, mem_rdata is captured into rdata of port gnt_id.
  - mem_rd_en and mem_wr_en are cleared. mem_adr and mem_wdata hold their values.
  - The ack of port gnt_id is set.
- DONE (one cycle):
  - pN_ack is high for gnt_id only.
  - Next state is always IDLE. The ack clears on that edge.
- Requester rule: pN_req, pN_we, pN_addr and pN_wdata are stable from assertion until the ack cycle. In the cycle after ack, the requester drops req or presents a new transaction.
- Writes never modify pN_rdata. A read modifies only the rdata of the granted port.
- Request inputs in ACCESS and DONE are ignored; no queueing.
- Exactly one memory access per transaction; no back-to-back enables. Enables are low in IDLE and DONE.

## Timing
- Reset values:
  - State IDLE; busy=0.
  - mem_adr=0, mem_wdata=0, mem_rd_en=0, mem_wr_en=0.
  - p0_ack=p1_ack=0; p0_rdata=p1_rdata=0.
  - last_grant=1, so port 0 wins the first tie.
- Latency: request sampled high in IDLE at cycle T -> enables high in T+1 -> ack high in T+2 -> IDLE in T+3.
- Throughput: one transaction per 3 cycles. Under continuous contention the ports alternate 0,1,0,1.
- busy is high in T+1 and T+2.
- pN_rdata is valid from the ack cycle onward.
- Simultaneous requests at reset release: port 0 first.
- Reset mid-operation:
  - rst during ACCESS: the in-flight memory edge occurs, because the memory is not reset by this block. The FSM goes to IDLE, all outputs take reset values, and no ack is issued.
  - rst during DONE: the ack is dropped at that edge.
- Reset priority: rst overrides every transition in the same cycle.
- Address/data arithmetic: none. Values pass through at full ADDR_W/DATA_W width, with no wrap or truncation.

## Test plan
- Single write then read, port 0:
  - Write p0 addr 0x10 data 0xA5. Expect mem_wr_en=1 only in T+1 and p0_ack in T+2.
  - Then read 0x10. Expect mem_rd_en one cycle, p0_rdata=0xA5 at ack, and p1_rdata still 0x00.
- Contention:
  - p0 and p1 both hold continuous read requests (0x01, 0x02) from reset.
  - Expect grants 0,1,0,1, acks every 3 cycles alternating, and no overlap of enables.
- Port isolation:
  - p1 reads 0x20 (preloaded 0x3C) while p0 idle. Expect p1_rdata=0x3C and p0_rdata unchanged.
  - Then p1 writes 0x20 with 0xFF. Expect p1_rdata to stay 0x3C.
- Tie-break after single use:
  - p1 alone completes a transaction; then both request in the same cycle.
  - Expect port 0 granted (last_grant=1).
- Reset during ACCESS:
  - Assert rst in the ACCESS cycle of a p0 write (addr 0x30, 0x77).
  - Expect no p0_ack, all outputs at reset values next cycle, and FSM IDLE.
  - A subsequent read of 0x30 by p1 returns 0x77.
- Request drop:
  - p0 pulses req for one cycle in IDLE. Expect a full transaction with ack.
  - Requests asserted during ACCESS/DONE by p1 are not served until IDLE.
